agc_ctrl: RTL

//  Digital automatic-gain-control loop for the CDR front end. Samples the differential output of the

---
 rtl/agc_pkg.sv | 28 ++
 rtl/agc_ctrl_if.sv | 31 +++
 rtl/agc_ctrl_peak_win.sv | 45 ++++
 rtl/agc_ctrl.sv | 98 +++++++++
 4 files changed

// File: rtl/agc_pkg.sv
// agc_pkg: shared types, constants and helpers for the AGC loop.
//   agc_state_t   : loop state (IDLE / ACQ / LOCKED)
//   GAIN_W        : width of the VCVGA gain code
//   GAIN_MAX      : largest gain code
//   wrealXState   : real value that marks an unknown analog level
//   wrealZState   : real value that marks an undriven analog level
//   absr()        : absolute value of a real
//   is_undriven() : true for either marker value
package agc_pkg;

  typedef enum logic [1:0] {IDLE, ACQ, LOCKED} agc_state_t;

  localparam int GAIN_W   = 3;
  localparam int GAIN_MAX = 7;

  // Marker values sit far outside any physical amplifier swing.
  localparam real wrealXState = -1.0e300;
  localparam real wrealZState = 1.0e300;

  function automatic real absr(input real v);
    return (v < 0.0) ? -v : v;
  endfunction

  function automatic logic is_undriven(input real v);
    return (v == wrealXState) || (v == wrealZState);
  endfunction

endpackage

// File: rtl/agc_ctrl_if.sv
// agc_ctrl_if: amplifier-side and sequencer-side signals of the AGC loop.
//   INP, INN : PGA differential output (real, V)
//   EN       : loop enable
//   PD       : powerdown
//   FREEZE   : measure without changing the gain code
//   VCVGA    : gain code to the PGA (7 = max gain)
//   LOCK     : peak in band for LOCK_WINS consecutive windows
//   SAT_HI   : last window wanted more gain at the top code
//   SAT_LO   : last window wanted less gain at code 0
// master drives the inputs (bench / sequencer); slave is the AGC controller.
interface agc_ctrl_if;
  real                        INP;
  real                        INN;
  logic                       EN;
  logic                       PD;
  logic                       FREEZE;
  logic [agc_pkg::GAIN_W-1:0] VCVGA;
  logic                       LOCK;
  logic                       SAT_HI;
  logic                       SAT_LO;

  modport master (
    output INP, INN, EN, PD, FREEZE,
    input  VCVGA, LOCK, SAT_HI, SAT_LO
  );

  modport slave (
    input  INP, INN, EN, PD, FREEZE,
    output VCVGA, LOCK, SAT_HI, SAT_LO
  );
endinterface

// File: rtl/agc_ctrl_peak_win.sv
// peak_win: sample window counter with peak hold of |INP-INN|.
//   i_clk      : sample clock
//   i_rst      : synchronous active-high reset
//   i_clear    : discard the partial window (loop idle)
//   i_inp/inn  : differential sample (real)
//   o_win_done : current sample is the last of the window
//   o_pk       : window peak including the current sample
module peak_win import agc_pkg::*; #(
  parameter int unsigned WIN_LEN = 32
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  real  i_inp,
  input  real  i_inn,
  output logic o_win_done,
  output real  o_pk
);
  localparam int unsigned CNT_W = $clog2(WIN_LEN);

  logic [CNT_W-1:0] r_cnt;
  real              r_peak;
  logic             w_skip;
  real              w_mag;

  // Peak is never negative, so an unusable sample folded to 0.0 leaves it
  // unchanged while the counter still advances.
  always_comb begin
    w_skip     = is_undriven(i_inp) || is_undriven(i_inn);
    w_mag      = w_skip ? 0.0 : absr(i_inp - i_inn);
    o_pk       = (w_mag > r_peak) ? w_mag : r_peak;
    o_win_done = (r_cnt == CNT_W'(WIN_LEN - 1));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear || o_win_done) begin
      r_cnt  <= '0;
      r_peak <= 0.0;
    end else begin
      r_cnt  <= r_cnt + CNT_W'(1);
      r_peak <= o_pk;
    end
  end

endmodule

// File: rtl/agc_ctrl.sv
// agc_ctrl: digital AGC loop for the CDR front end. Measures the peak
// differential PGA output per window and steps the gain code by one to keep
// the peak within [VREF_LO, VREF_HI].
//   CLK    : sample clock
//   RST    : synchronous active-high reset
//   if_agc : agc_ctrl_if.slave (INP/INN/EN/PD/FREEZE in; VCVGA/LOCK/SAT_* out)
module agc_ctrl import agc_pkg::*; #(
  parameter int unsigned WIN_LEN   = 32,
  parameter real         VREF_LO   = 0.35,
  parameter real         VREF_HI   = 0.45,
  parameter int unsigned LOCK_WINS = 4,
  parameter int unsigned CODE_INIT = 3
) (
  input logic       CLK,
  input logic       RST,
  agc_ctrl_if.slave if_agc
);
  localparam int unsigned INB_W = $clog2(LOCK_WINS + 1);

  agc_state_t        r_state, w_state_nxt;
  logic [GAIN_W-1:0] r_code, w_code_nxt;
  logic [INB_W-1:0]  r_inband, w_inband_nxt;
  logic              r_sat_hi, w_sat_hi_nxt;
  logic              r_sat_lo, w_sat_lo_nxt;
  logic              w_active;
  logic              w_win_done;
  real               w_pk;

  assign w_active = if_agc.EN && !if_agc.PD;

  peak_win #(.WIN_LEN(WIN_LEN)) u_peak_win (
    .i_clk      (CLK),
    .i_rst      (RST),
    .i_clear    (!w_active),
    .i_inp      (if_agc.INP),
    .i_inn      (if_agc.INN),
    .o_win_done (w_win_done),
    .o_pk       (w_pk)
  );

  // LOCKED is exactly "inband count saturated", so the next state follows
  // from the next inband count; any out-of-band window (code step or not)
  // zeroes it and drops back to ACQ.
  always_comb begin
    w_state_nxt  = r_state;
    w_code_nxt   = r_code;
    w_inband_nxt = r_inband;
    w_sat_hi_nxt = r_sat_hi;
    w_sat_lo_nxt = r_sat_lo;
    if (!w_active) begin
      w_state_nxt  = IDLE;
      w_inband_nxt = '0;
    end else begin
      if (w_win_done) begin
        w_sat_hi_nxt = 1'b0;
        w_sat_lo_nxt = 1'b0;
        if (w_pk > VREF_HI) begin
          w_inband_nxt = '0;
          if (r_code == '0)
            w_sat_lo_nxt = 1'b1;
          else if (!if_agc.FREEZE)
            w_code_nxt = r_code - GAIN_W'(1);
        end else if (w_pk < VREF_LO) begin
          w_inband_nxt = '0;
          if (r_code == GAIN_W'(GAIN_MAX))
            w_sat_hi_nxt = 1'b1;
          else if (!if_agc.FREEZE)
            w_code_nxt = r_code + GAIN_W'(1);
        end else if (r_inband != INB_W'(LOCK_WINS)) begin
          w_inband_nxt = r_inband + INB_W'(1);
        end
      end
      w_state_nxt = (w_inband_nxt == INB_W'(LOCK_WINS)) ? LOCKED : ACQ;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= IDLE;
      r_code   <= GAIN_W'(CODE_INIT);
      r_inband <= '0;
      r_sat_hi <= 1'b0;
      r_sat_lo <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_code   <= w_code_nxt;
      r_inband <= w_inband_nxt;
      r_sat_hi <= w_sat_hi_nxt;
      r_sat_lo <= w_sat_lo_nxt;
    end
  end

  assign if_agc.VCVGA  = r_code;
  assign if_agc.LOCK   = (r_state == LOCKED);
  assign if_agc.SAT_HI = r_sat_hi;
  assign if_agc.SAT_LO = r_sat_lo;

endmodule
